// File: rtl/btn_conditioner.sv
`default_nettype none
// ============================================================================
// Module     : btn_conditioner
// Purpose    : N-channel button synchroniser + counter debouncer with level,
//              press and release outputs; auto-repeat when BTN_AUTOREPEAT_EN.
// Revision   : 1.0  initial release
// ============================================================================
module btn_conditioner #(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter bit BTN_ACTIVE_LOW  = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] btn_raw_i,
    output logic [CHANNELS-1:0] btn_level_o,
    output logic [CHANNELS-1:0] btn_press_o,
    output logic [CHANNELS-1:0] btn_release_o,
    output logic                any_press_o
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PEND_PRESS   = 2'd1,
        PRESSED      = 2'd2,
        PEND_RELEASE = 2'd3
    } state_t;

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 ||
        (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_param_check
        $error("btn_conditioner: illegal parameter combination");
    end

    logic [CHANNELS-1:0] btn_pol_d;
    logic [CHANNELS-1:0] sync1_q;
    logic [CHANNELS-1:0] sync2_q;

    assign btn_pol_d = BTN_ACTIVE_LOW ? ~btn_raw_i : btn_raw_i;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_pol_d;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        state_t           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             level_q;
        logic             press_q;
        logic             release_q;
        logic             rpt_fire_d;

`ifdef BTN_AUTOREPEAT_EN
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RPT_W   = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
        localparam logic [RPT_W-1:0] RPT_DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
        localparam logic [RPT_W-1:0] RPT_PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);
        localparam logic [RPT_W-1:0] RPT_ONE         = RPT_W'(1);

        logic [RPT_W-1:0] rpt_q;
        logic             rpt_first_q;
        logic             held_d;

        // The counter sits at zero until the press is accepted, so its first
        // tick lands on the cycle after the accepting edge.
        assign held_d     = (state_q == PRESSED) || (state_q == PEND_RELEASE);
        assign rpt_fire_d = held_d &&
                            (rpt_q == (rpt_first_q ? RPT_DELAY_LAST : RPT_PERIOD_LAST));

        always_ff @(posedge clk) begin
            if (!reset || !held_d) begin
                rpt_q       <= '0;
                rpt_first_q <= 1'b1;
            end else if (rpt_fire_d) begin
                rpt_q       <= '0;
                rpt_first_q <= 1'b0;
            end else begin
                rpt_q <= rpt_q + RPT_ONE;
            end
        end
`else
        assign rpt_fire_d = 1'b0;
`endif

        always_ff @(posedge clk) begin
            if (!reset) begin
                state_q   <= RELEASED;
                cnt_q     <= '0;
                level_q   <= 1'b0;
                press_q   <= 1'b0;
                release_q <= 1'b0;
            end else begin
                press_q   <= 1'b0;
                release_q <= 1'b0;
                case (state_q)
                    RELEASED: begin
                        if (sync2_q[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q <= PRESSED;
                                level_q <= 1'b1;
                                press_q <= 1'b1;
                            end else begin
                                state_q <= PEND_PRESS;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    PEND_PRESS: begin
                        if (!sync2_q[i]) begin
                            state_q <= RELEASED;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q <= PRESSED;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + CNT_ONE;
                        end
                    end
                    PRESSED: begin
                        press_q <= rpt_fire_d;
                        if (!sync2_q[i]) begin
                            if (DEBOUNCE_CYCLES == 1) begin
                                state_q   <= RELEASED;
                                level_q   <= 1'b0;
                                release_q <= 1'b1;
                                press_q   <= 1'b0;
                            end else begin
                                state_q <= PEND_RELEASE;
                                cnt_q   <= CNT_ONE;
                            end
                        end
                    end
                    PEND_RELEASE: begin
                        if (sync2_q[i]) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                            press_q <= rpt_fire_d;
                        end else if (cnt_q == CNT_LAST) begin
                            state_q   <= RELEASED;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                            cnt_q     <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_ONE;
                            press_q <= rpt_fire_d;
                        end
                    end
                    default: begin
                        state_q <= RELEASED;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end

        assign btn_level_o[i]   = level_q;
        assign btn_press_o[i]   = press_q;
        assign btn_release_o[i] = release_q;
    end

    assign any_press_o = |btn_press_o;

endmodule
`default_nettype wire
